// File: rtl/cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// cpu_control_fsm
// Instruction sequencer for a 16-entry register file. Accepts one 16-bit
// instruction per valid/ready handshake, then walks through register reads, an
// ALU step, a single writeback, a whole-file clear or a display latch. It issues
// one register-file access per cycle.
//
// Instruction format: [15:13] opcode, [12:9] dest, [8:5] src1, [4:0] imm
// (src2 = [3:0]).
//
// Ports
//   clock_i          rising-edge clock
//   reset_ni         asynchronous active-low reset
//   instr_valid_i    instr_i holds a valid instruction
//   instr_i          instruction word
//   instr_ready_o    high only while idle
//   busy_o           high in every state except idle
//   done_o           one-cycle pulse when the instruction retires
//   rf_addr_o        register index for the current read or write
//   rf_rdata_i       combinational read data of register[rf_addr_o]
//   rf_we_o          write strobe (rf_wdata_o -> register[rf_addr_o])
//   rf_wdata_o       write data
//   rf_clear_o       one-cycle strobe that zeroes the whole register file
//   display_value_o  last value fetched by DISPLAY
//   flag_ovf_o       carry / borrow / product overflow of the last arithmetic op
// -----------------------------------------------------------------------------
module cpu_control_fsm #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int IMM_W  = 5
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              instr_valid_i,
  input  logic [15:0]       instr_i,
  output logic              instr_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic              rf_we_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              rf_clear_o,
  output logic [DATA_W-1:0] display_value_o,
  output logic              flag_ovf_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WRITE, S_CLR, S_DISP, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_CLEAR, OP_DISPLAY
  } opcode_e;

  state_e            state_q, state_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic              flag_ovf_q, flag_ovf_d;

  // Fields of the latched instruction.
  opcode_e           opcode;
  logic [ADDR_W-1:0] dest, src1, src2;
  logic [DATA_W-1:0] imm_ext;

  assign opcode  = opcode_e'(instr_q[15:13]);
  assign dest    = instr_q[12:9];
  assign src1    = instr_q[8:5];
  assign src2    = instr_q[3:0];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_W-1:0]};

  // ALU. Immediate forms take the zero-extended imm as the second operand
  // instead of a register read, so they skip RD_B.
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   diff;
  logic                borrow;
  logic [2*DATA_W-1:0] prod;

  assign alu_b  = (opcode == OP_ADDI || opcode == OP_SUBI) ? imm_ext : op_b_q;
  assign sum    = {1'b0, op_a_q} + {1'b0, alu_b};
  assign diff   = op_a_q - alu_b;
  assign borrow = (op_a_q < alu_b);
  assign prod   = {{DATA_W{1'b0}}, op_a_q} * {{DATA_W{1'b0}}, alu_b};

  assign display_value_o = display_q;
  assign flag_ovf_o      = flag_ovf_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    instr_d       = instr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    result_d      = result_q;
    display_d     = display_q;
    flag_ovf_d    = flag_ovf_q;
    instr_ready_o = 1'b0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    rf_addr_o     = '0;
    rf_we_o       = 1'b0;
    rf_wdata_o    = '0;
    rf_clear_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        busy_o        = 1'b0;
        if (instr_valid_i) begin
          instr_d = instr_i;
          case (opcode_e'(instr_i[15:13]))
            OP_LOAD:    state_d = S_WRITE;
            OP_CLEAR:   state_d = S_CLR;
            OP_DISPLAY: state_d = S_DISP;
            default:    state_d = S_RD_A;
          endcase
        end
      end
      S_RD_A: begin
        rf_addr_o = src1;
        op_a_d    = rf_rdata_i;
        state_d   = (opcode == OP_ADDI || opcode == OP_SUBI) ? S_EXEC : S_RD_B;
      end
      S_RD_B: begin
        rf_addr_o = src2;
        op_b_d    = rf_rdata_i;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_ADDI: begin
            result_d   = sum[DATA_W-1:0];
            flag_ovf_d = sum[DATA_W];
          end
          OP_SUB, OP_SUBI: begin
            result_d   = diff;
            flag_ovf_d = borrow;
          end
          OP_MUL: begin
            result_d   = prod[DATA_W-1:0];
            flag_ovf_d = |prod[2*DATA_W-1:DATA_W];
          end
          default: ;
        endcase
        state_d = S_WRITE;
      end
      S_WRITE: begin
        rf_we_o    = 1'b1;
        rf_addr_o  = dest;
        // LOAD reaches WRITE straight from IDLE; its data is the immediate.
        rf_wdata_o = (opcode == OP_LOAD) ? imm_ext : result_q;
        state_d    = S_DONE;
      end
      S_CLR: begin
        rf_clear_o = 1'b1;
        state_d    = S_DONE;
      end
      S_DISP: begin
        rf_addr_o = dest;
        display_d = rf_rdata_i;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      display_q  <= '0;
      flag_ovf_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      instr_q    <= instr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      display_q  <= display_d;
      flag_ovf_q <= flag_ovf_d;
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_fsm
// Bench for cpu_control_fsm. Provides a behavioural 16x16 register file, an
// architectural model of the instruction set (register contents, flag, display
// value, retire latency) and per-scenario tasks with inline comparisons.
// -----------------------------------------------------------------------------
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready, busy, done;
  logic [3:0]  rf_addr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        rf_clear;
  logic [15:0] display_value;
  logic        flag_ovf;

  always #5 clk = ~clk;

  cpu_control_fsm dut (
    .clock_i         (clk),
    .reset_ni        (rst_n),
    .instr_valid_i   (instr_valid),
    .instr_i         (instr),
    .instr_ready_o   (instr_ready),
    .busy_o          (busy),
    .done_o          (done),
    .rf_addr_o       (rf_addr),
    .rf_rdata_i      (rf_rdata),
    .rf_we_o         (rf_we),
    .rf_wdata_o      (rf_wdata),
    .rf_clear_o      (rf_clear),
    .display_value_o (display_value),
    .flag_ovf_o      (flag_ovf)
  );

  // Register file attached to the sequencer.
  logic [15:0] rf [16] = '{default: 16'h0000};
  assign rf_rdata = rf[rf_addr];
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
    end else if (rf_we) begin
      rf[rf_addr] <= rf_wdata;
    end
  end

  // Architectural model state.
  int unsigned m_reg [16];
  int unsigned m_disp;
  bit          m_flag;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [3:0] d,
                                      input logic [3:0] s1, input logic [4:0] imm);
    return {op, d, s1, imm};
  endfunction

  // Waits for the idle cycle, presents ins, and returns 1 time unit after the
  // accepting edge. With keep set, instr_valid stays high afterwards.
  task automatic drive_accept(input logic [15:0] ins, input bit keep);
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_accept: ready=%b busy=%b done=%b, need 1 0 0",
               instr_ready, busy, done);
    end
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1;
    if (!keep) instr_valid = 1'b0;
  endtask

  // Follows one accepted instruction until it retires and checks it against
  // the model, then advances the model.
  task automatic monitor(input logic [15:0] ins);
    int op  = int'(ins[15:13]);
    int d   = int'(ins[12:9]);
    int s1  = int'(ins[8:5]);
    int s2  = int'(ins[3:0]);
    int imm = int'(ins[4:0]);
    int lat = 2, exp_we = 0, exp_clr = 0;
    bit arith = 0, ovf = 0;
    int unsigned a = 0, b = 0, r = 0;
    longint unsigned full;
    int done_cyc = 0, we_cnt = 0, we_cyc = 0, clr_cnt = 0, bad_regs = 0;

    case (op)
      0: begin r = imm; exp_we = 1; end
      1, 2: begin
        a = m_reg[s1]; b = (op == 2) ? imm : m_reg[s2];
        full = longint'(a) + longint'(b);
        r = int'(full % 65536); ovf = full > 65535;
        arith = 1; exp_we = 1; lat = (op == 2) ? 4 : 5;
      end
      3, 4: begin
        a = m_reg[s1]; b = (op == 4) ? imm : m_reg[s2];
        ovf = a < b; r = (a + 65536 - b) % 65536;
        arith = 1; exp_we = 1; lat = (op == 4) ? 4 : 5;
      end
      5: begin
        a = m_reg[s1]; b = m_reg[s2];
        full = longint'(a) * longint'(b);
        r = int'(full % 65536); ovf = full > 65535;
        arith = 1; exp_we = 1; lat = 5;
      end
      6: exp_clr = 1;
      default: ;
    endcase

    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || instr_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready op=%0d cyc=%0d: busy=%b ready=%b, need 1 0",
                 op, cyc, busy, instr_ready);
      end
      if (rf_we === 1'b1) begin
        we_cnt++; we_cyc = cyc;
        checks++;
        if (rf_addr !== 4'(d) || rf_wdata !== 16'(r)) begin
          errors++;
          $display("FAIL write op=%0d: addr=%0d data=%h, need addr=%0d data=%h",
                   op, rf_addr, rf_wdata, d, 16'(r));
        end
      end
      if (rf_clear === 1'b1) clr_cnt++;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
    end

    checks++;
    if (done_cyc != lat) begin
      errors++;
      $display("FAIL done_latency op=%0d: done in cycle %0d, need %0d (0 = timeout)",
               op, done_cyc, lat);
    end
    checks++;
    if (we_cnt != exp_we || (exp_we == 1 && we_cyc != lat - 1)) begin
      errors++;
      $display("FAIL write_count op=%0d: %0d writes (last cycle %0d), need %0d in cycle %0d",
               op, we_cnt, we_cyc, exp_we, lat - 1);
    end
    checks++;
    if (clr_cnt != exp_clr) begin
      errors++;
      $display("FAIL clear_count op=%0d: %0d clear strobes, need %0d", op, clr_cnt, exp_clr);
    end

    if (exp_we == 1) m_reg[d] = r;
    if (arith) m_flag = ovf;
    if (exp_clr == 1) for (int i = 0; i < 16; i++) m_reg[i] = 0;
    if (op == 7) m_disp = m_reg[d];

    checks++;
    if (flag_ovf !== m_flag) begin
      errors++;
      $display("FAIL flag_ovf op=%0d: got %b, need %b", op, flag_ovf, m_flag);
    end
    checks++;
    if (display_value !== 16'(m_disp)) begin
      errors++;
      $display("FAIL display_value op=%0d: got %h, need %h", op, display_value, 16'(m_disp));
    end
    for (int i = 0; i < 16; i++) if (rf[i] !== 16'(m_reg[i])) bad_regs++;
    checks++;
    if (bad_regs != 0) begin
      errors++;
      $display("FAIL regfile op=%0d: %0d registers differ from model, need 0", op, bad_regs);
    end
  endtask

  task automatic run(input logic [15:0] ins);
    drive_accept(ins, 1'b0);
    monitor(ins);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0 ||
        rf_clear !== 1'b0 || rf_addr !== 4'h0 || rf_wdata !== 16'h0 ||
        display_value !== 16'h0 || flag_ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b busy=%b done=%b we=%b clr=%b addr=%h wdata=%h disp=%h ovf=%b, need ready=1 rest 0",
               tag, instr_ready, busy, done, rf_we, rf_clear, rf_addr, rf_wdata,
               display_value, flag_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    check_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    m_flag = 0; m_disp = 0;
  endtask

  task automatic test_reset_mid_add();
    run(enc(3'd0, 4'd1, 4'd0, 5'd31));
    run(enc(3'd0, 4'd2, 4'd0, 5'd5));
    drive_accept(enc(3'd1, 4'd4, 4'd1, 5'd2), 1'b0);
    @(posedge clk);               // RD_A -> RD_B
    #1;
    rst_n = 1'b0;
    m_flag = 0; m_disp = 0;
    #1;
    check_reset_outputs("reset_mid_add");
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("reset_held");
    end
    rst_n = 1'b1;
    checks++;
    if (rf[4] !== 16'(m_reg[4])) begin
      errors++;
      $display("FAIL aborted_add_r4: got %h, need %h", rf[4], 16'(m_reg[4]));
    end
  endtask

  task automatic test_load_display();
    run(enc(3'd0, 4'd3, 4'd0, 5'd21));
    run(enc(3'd7, 4'd3, 4'd0, 5'd0));
    checks++;
    if (display_value !== 16'h0015) begin
      errors++;
      $display("FAIL display_r3: got %h, need 0015", display_value);
    end
  endtask

  task automatic test_arith();
    run(enc(3'd0, 4'd1, 4'd0, 5'd31));
    run(enc(3'd0, 4'd2, 4'd0, 5'd5));
    run(enc(3'd1, 4'd4, 4'd1, 5'd2));
    checks++;
    if (rf[4] !== 16'h0024 || flag_ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_r4: got %h ovf=%b, need 0024 ovf=0", rf[4], flag_ovf);
    end
    run(enc(3'd3, 4'd5, 4'd2, 5'd1));
    checks++;
    if (rf[5] !== 16'hFFE6 || flag_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_r5: got %h ovf=%b, need ffe6 ovf=1", rf[5], flag_ovf);
    end
  endtask

  task automatic test_addi_wrap();
    run(enc(3'd0, 4'd1, 4'd0, 5'd0));
    run(enc(3'd0, 4'd2, 4'd0, 5'd1));
    run(enc(3'd3, 4'd1, 4'd1, 5'd2));   // R1 = 0 - 1 = 0xFFFF
    run(enc(3'd2, 4'd1, 4'd1, 5'd1));   // R1 = 0xFFFF + 1
    checks++;
    if (rf[1] !== 16'h0000 || flag_ovf !== 1'b1) begin
      errors++;
      $display("FAIL addi_wrap_r1: got %h ovf=%b, need 0000 ovf=1", rf[1], flag_ovf);
    end
  endtask

  task automatic test_mul_clear();
    run(enc(3'd0, 4'd6, 4'd0, 5'd16));
    run(enc(3'd5, 4'd6, 4'd6, 5'd6));   // R6 = 0x0100
    run(enc(3'd5, 4'd7, 4'd6, 5'd6));   // R7 = 0x0100 * 0x0100
    checks++;
    if (rf[7] !== 16'h0000 || flag_ovf !== 1'b1) begin
      errors++;
      $display("FAIL mul_r7: got %h ovf=%b, need 0000 ovf=1", rf[7], flag_ovf);
    end
    run(enc(3'd6, 4'd0, 4'd0, 5'd0));
    checks++;
    if (flag_ovf !== 1'b1 || rf[6] !== 16'h0000) begin
      errors++;
      $display("FAIL clear_keeps_flag: ovf=%b r6=%h, need ovf=1 r6=0000", flag_ovf, rf[6]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] first  = enc(3'd0, 4'd9, 4'd0, 5'd27);
    logic [15:0] second = enc(3'd2, 4'd10, 4'd9, 5'd9);
    drive_accept(first, 1'b1);
    instr = second;                   // valid stays high while busy
    monitor(first);
    drive_accept(second, 1'b0);       // must be idle exactly one cycle after done
    monitor(second);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      logic [15:0] ins = 16'($urandom);
      // Bias toward writes so arithmetic sees non-trivial register contents.
      if (($urandom % 4) == 0) ins[15:13] = 3'd0;
      run(ins);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_reg[i] = 0;
    m_flag = 0; m_disp = 0;
    test_reset();
    test_reset_mid_add();
    test_load_display();
    test_arith();
    test_addi_wrap();
    test_mul_clear();
    test_back_to_back();
    test_random(60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
